// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } hz_state_t;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Next-cycle EX operand forwarding select for one source operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use_rs,
  input  logic [REG_ADDR_W-1:0] i_rd_ex,
  input  logic                  i_regwrite_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_mem,
  input  logic                  i_regwrite_mem,
  output fwd_sel_t              o_sel
);

  logic w_hit_ex;
  logic w_hit_mem;

  assign w_hit_ex  = i_use_rs && i_regwrite_ex && (i_rd_ex != REG_ADDR_W'(REG_X0))
                     && (i_rd_ex == i_rs);
  assign w_hit_mem = i_use_rs && i_regwrite_mem && (i_rd_mem != REG_ADDR_W'(REG_X0))
                     && (i_rd_mem == i_rs);

  // Newest producer wins: EX/MEM result shadows the older WB result.
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex)       o_sel = FWD_EXMEM;
    else if (w_hit_mem) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush control,
// event statistics and a memory-freeze watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_rs1_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_id,
  input  logic                  i_use_rs1_id,
  input  logic                  i_use_rs2_id,
  input  logic [REG_ADDR_W-1:0] i_rd_ex,
  input  logic                  i_regwrite_ex,
  input  logic                  i_memread_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_mem,
  input  logic                  i_regwrite_mem,
  input  logic                  i_branch_taken_ex,
  input  logic                  i_mem_busy,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_idex_write,
  output logic                  o_flush_ifid,
  output logic                  o_flush_idex,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt,
  output logic                  o_timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  hz_state_t        r_state, w_state_nxt;
  fwd_sel_t         r_fwd_a, r_fwd_b;
  fwd_sel_t         w_fwd_a_nxt, w_fwd_b_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [WD_W-1:0]  r_wd_ctr;
  logic             r_timeout_err;
  logic             w_hit_rs1, w_hit_rs2, w_load_use;
  logic             w_freeze, w_branch, w_lu_stall;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs          (i_rs1_id),
    .i_use_rs      (i_use_rs1_id),
    .i_rd_ex       (i_rd_ex),
    .i_regwrite_ex (i_regwrite_ex),
    .i_rd_mem      (i_rd_mem),
    .i_regwrite_mem(i_regwrite_mem),
    .o_sel         (w_fwd_a_nxt)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs          (i_rs2_id),
    .i_use_rs      (i_use_rs2_id),
    .i_rd_ex       (i_rd_ex),
    .i_regwrite_ex (i_regwrite_ex),
    .i_rd_mem      (i_rd_mem),
    .i_regwrite_mem(i_regwrite_mem),
    .o_sel         (w_fwd_b_nxt)
  );

  assign w_hit_rs1  = i_use_rs1_id && (i_rd_ex == i_rs1_id);
  assign w_hit_rs2  = i_use_rs2_id && (i_rd_ex == i_rs2_id);
  assign w_load_use = i_memread_ex && i_regwrite_ex && (i_rd_ex != REG_ADDR_W'(REG_X0))
                      && (w_hit_rs1 || w_hit_rs2);
  assign w_freeze   = i_mem_busy;
  assign w_branch   = i_branch_taken_ex && !w_freeze;
  assign w_lu_stall = w_load_use && !w_freeze && !i_branch_taken_ex;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // Enables/flushes are driven from live inputs so a hazard acts the same cycle;
  // the state only tracks which regime the pipeline is in.
  always_comb begin
    w_state_nxt  = r_state;
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_idex_write = 1'b1;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    if (w_freeze) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_idex_write = 1'b0;
    end else if (w_branch) begin
      o_flush_ifid = 1'b1;
      o_flush_idex = 1'b1;
    end else if (w_lu_stall) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_flush_idex = 1'b1;
    end
    case (r_state)
      RUN:      if (w_freeze)        w_state_nxt = FREEZE;
                else if (w_lu_stall) w_state_nxt = LU_STALL;
      LU_STALL: w_state_nxt = w_freeze ? FREEZE : RUN;
      FREEZE:   if (!w_freeze)       w_state_nxt = w_lu_stall ? LU_STALL : RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!w_freeze) begin
      r_fwd_a <= o_flush_idex ? FWD_RF : w_fwd_a_nxt;
      r_fwd_b <= o_flush_idex ? FWD_RF : w_fwd_b_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Watchdog counts down from TIMEOUT while busy; terminal count 1 -> 0 marks expiry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_ctr      <= WD_W'(TIMEOUT);
      r_timeout_err <= 1'b0;
    end else if (!w_freeze) begin
      r_wd_ctr <= WD_W'(TIMEOUT);
    end else begin
      if (r_wd_ctr != '0)         r_wd_ctr <= r_wd_ctr - WD_W'(1);
      if (r_wd_ctr == WD_W'(1))   r_timeout_err <= 1'b1;
    end
  end

  assign o_fwd_a_sel   = r_fwd_a;
  assign o_fwd_b_sel   = r_fwd_b;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (narrow counters to reach saturation).
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic          use_rs1_id, use_rs2_id, regwrite_ex, memread_ex, regwrite_mem;
  logic          branch_taken_ex, mem_busy;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_write, ifid_write, idex_write, flush_ifid, flush_idex;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .TIMEOUT(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
    .i_use_rs1_id(use_rs1_id), .i_use_rs2_id(use_rs2_id),
    .i_rd_ex(rd_ex), .i_regwrite_ex(regwrite_ex), .i_memread_ex(memread_ex),
    .i_rd_mem(rd_mem), .i_regwrite_mem(regwrite_mem),
    .i_branch_taken_ex(branch_taken_ex), .i_mem_busy(mem_busy),
    .o_fwd_a_sel(fwd_a_sel), .o_fwd_b_sel(fwd_b_sel),
    .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_idex_write(idex_write),
    .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt),
    .o_timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rd_ex = '0; rd_mem = '0;
    use_rs1_id = 0; use_rs2_id = 0; regwrite_ex = 0; memread_ex = 0;
    regwrite_mem = 0; branch_taken_ex = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ctl = {pc_write, ifid_write, idex_write, flush_ifid, flush_idex}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {pc_write, ifid_write, idex_write, flush_ifid, flush_idex}, exp);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
    chk("rst_err", timeout_err, 0);
    chk_ctl("rst_ctl", 5'b11100);
    @(negedge clk);
    rst_n = 1;

    // 1: EX forward on operand A
    rd_ex = 5; regwrite_ex = 1; rs1_id = 5; use_rs1_id = 1; rs2_id = 6; use_rs2_id = 1;
    chk_ctl("t1_ctl", 5'b11100);
    tick();
    chk("t1_fwd_a", fwd_a_sel, 2'b10);
    chk("t1_fwd_b", fwd_b_sel, 2'b00);

    // 2: EX beats MEM; MEM alone gives 01; use=0 forces 00
    idle();
    rd_ex = 7; rd_mem = 7; regwrite_ex = 1; regwrite_mem = 1;
    rs2_id = 7; use_rs2_id = 1; rs1_id = 1; use_rs1_id = 1;
    tick();
    chk("t2_fwd_b_ex", fwd_b_sel, 2'b10);
    chk("t2_fwd_a", fwd_a_sel, 2'b00);
    regwrite_ex = 0;
    tick();
    chk("t2_fwd_b_mem", fwd_b_sel, 2'b01);
    use_rs2_id = 0;
    tick();
    chk("t2_fwd_b_nouse", fwd_b_sel, 2'b00);

    // 3: load-use bubble then WB forward
    idle();
    memread_ex = 1; regwrite_ex = 1; rd_ex = 3; rs1_id = 3; use_rs1_id = 1;
    chk_ctl("t3_lu_ctl", 5'b00101);
    chk("t3_stall_pre", stall_cnt, 0);
    tick();
    chk("t3_stall_cnt", stall_cnt, 1);
    chk("t3_fwd_bubble", fwd_a_sel, 2'b00);
    memread_ex = 0; regwrite_ex = 0; rd_ex = 0; rd_mem = 3; regwrite_mem = 1;
    chk_ctl("t3_post_ctl", 5'b11100);
    tick();
    chk("t3_fwd_wb", fwd_a_sel, 2'b01);

    // 4: branch wins over load-use
    do_reset();
    memread_ex = 1; regwrite_ex = 1; rd_ex = 3; rs1_id = 3; use_rs1_id = 1; branch_taken_ex = 1;
    chk_ctl("t4_ctl", 5'b11111);
    tick();
    chk("t4_flush_cnt", flush_cnt, 1);
    chk("t4_stall_cnt", stall_cnt, 0);
    chk("t4_fwd_a", fwd_a_sel, 2'b00);

    // 5: freeze holds selects/counters; watchdog
    idle();
    rd_ex = 5; regwrite_ex = 1; rs1_id = 5; use_rs1_id = 1;
    tick();
    chk("t5_fwd_pre", fwd_a_sel, 2'b10);
    mem_busy = 1; branch_taken_ex = 1; rd_ex = 0;
    chk_ctl("t5_frz_ctl", 5'b00000);
    ticks(4);
    chk("t5_fwd_hold", fwd_a_sel, 2'b10);
    chk("t5_cnts_hold", {stall_cnt, flush_cnt}, {4'd0, 4'd1});
    chk("t5_err_short", timeout_err, 0);
    mem_busy = 0; branch_taken_ex = 0; rd_ex = 5;
    tick();
    mem_busy = 1;
    ticks(254);
    chk("t5_err_254", timeout_err, 0);
    tick();
    chk("t5_err_255", timeout_err, 1);
    mem_busy = 0;
    tick();
    chk("t5_err_sticky", timeout_err, 1);
    mem_busy = 1;
    tick();
    mem_busy = 0; memread_ex = 1;
    chk_ctl("t5_unfreeze_lu", 5'b00101);
    tick();
    chk("t5_unfreeze_stall", stall_cnt, 1);

    // reset asserted mid-freeze
    memread_ex = 0;
    tick();
    chk("t6_fwd_pre", fwd_a_sel, 2'b10);
    mem_busy = 1;
    ticks(2);
    #3;
    rst_n = 0; mem_busy = 0;
    #1;
    chk("t6_rst_fwd", fwd_a_sel, 0);
    chk("t6_rst_err", timeout_err, 0);
    chk("t6_rst_cnts", {stall_cnt, flush_cnt}, 0);
    chk_ctl("t6_rst_ctl", 5'b11100);
    @(negedge clk);
    rst_n = 1;
    idle();
    tick();
    chk("t6_post_fwd", fwd_a_sel, 0);
    chk_ctl("t6_post_ctl", 5'b11100);

    // 6: x0 never matches
    rd_ex = 0; regwrite_ex = 1; memread_ex = 1; rs1_id = 0; use_rs1_id = 1;
    chk_ctl("t6_x0_ctl", 5'b11100);
    tick();
    chk("t6_x0_fwd", fwd_a_sel, 0);
    chk("t6_x0_stall", stall_cnt, 0);

    // saturation of both counters
    idle();
    memread_ex = 1; regwrite_ex = 1; rd_ex = 3; rs1_id = 3; use_rs1_id = 1;
    ticks(15);
    chk("sat_stall_15", stall_cnt, 15);
    tick();
    chk("sat_stall_hold", stall_cnt, 15);
    branch_taken_ex = 1;
    ticks(17);
    chk("sat_flush", flush_cnt, 15);
    chk("sat_stall_nochg", stall_cnt, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
